// File: rtl/fadd_issue_if.sv
// Request and result handshakes of the fadd issue/collect stage.
// master is the producer/consumer side, slave is the issue stage itself.
interface fadd_issue_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_x1;
  logic [31:0]      in_x2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_x1, in_x2, in_tag, out_ready,
    input  in_ready, out_valid, out_y, out_tag
  );

  modport slave (
    input  in_valid, in_x1, in_x2, in_tag, out_ready,
    output in_ready, out_valid, out_y, out_tag
  );
endinterface

// File: rtl/fadd_issue.sv
// Issue/collect stage around a fixed-latency pipelined fadd: tracks in-flight
// tags, catches each result on its arrival edge and returns them in order.
module fadd_issue #(
  parameter int NSTAGE = 3,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4
) (
  input  logic         clk,
  input  logic         rst,
  fadd_issue_if.slave  io,
  output logic [31:0]  fadd_x1,
  output logic [31:0]  fadd_x2,
  input  logic [31:0]  fadd_y,
  output logic         busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + NSTAGE) + 1;

  logic [NSTAGE-1:0] sr_valid;
  logic [NSTAGE-1:0] sr_valid_next;
  logic [TAG_W-1:0]  sr_tag      [NSTAGE];
  logic [TAG_W-1:0]  sr_tag_next [NSTAGE];

  logic [31:0]       mem_y   [DEPTH];
  logic [TAG_W-1:0]  mem_tag [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     inflight;

  logic accept;
  logic push;
  logic pop;

  assign accept = io.in_valid & io.in_ready;
  assign push   = sr_valid[NSTAGE-1];
  assign pop    = io.out_valid & io.out_ready;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      inflight = inflight + CW'(sr_valid[i]);
    end
  end

  // Every accepted op holds a credit from issue until it is popped, so a
  // FIFO slot is always free when its result reaches the tail.
  assign io.in_ready = !rst && ((inflight + count) < CW'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fadd_x1 <= '0;
      fadd_x2 <= '0;
    end else if (accept) begin
      fadd_x1 <= io.in_x1;
      fadd_x2 <= io.in_x2;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NSTAGE; gi++) begin : g_sr
      if (gi == 0) begin : g_head
        assign sr_valid_next[gi] = accept;
        assign sr_tag_next[gi]   = io.in_tag;
      end else begin : g_shift
        assign sr_valid_next[gi] = sr_valid[gi-1];
        assign sr_tag_next[gi]   = sr_tag[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_valid <= '0;
      for (int i = 0; i < NSTAGE; i++) begin
        sr_tag[i] <= '0;
      end
    end else begin
      sr_valid <= sr_valid_next;
      sr_tag   <= sr_tag_next;
    end
  end

  // fadd_y is only meaningful on the edge where a valid entry leaves the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_y[wr_ptr]   <= fadd_y;
      mem_tag[wr_ptr] <= sr_tag[NSTAGE-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign io.out_valid = (count != '0);
  assign io.out_y     = io.out_valid ? mem_y[rd_ptr]   : '0;
  assign io.out_tag   = io.out_valid ? mem_tag[rd_ptr] : '0;
  assign busy         = (inflight != '0) | (count != '0);
endmodule
